// File: rtl/approx_mult_pkg.sv
// Shared widths and FSM state type for the approximate-multiplier
// error characterisation blocks.
package approx_mult_pkg;

    localparam int OP_W      = 8;
    localparam int PROD_W    = 16;
    localparam int ERR_W     = 18;
    localparam int ABS_W     = 17;
    localparam int SQ_W      = 32;
    localparam int SSE_W     = 48;
    localparam int ERR_SUM_W = 34;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/approx_err_stage.sv
// Registered error stage: recomputes the exact product and registers the
// signed error z - x*y together with its valid bit.
module approx_err_stage
    import approx_mult_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic [OP_W-1:0]         x,
    input  logic [OP_W-1:0]         y,
    input  logic [PROD_W-1:0]       z,
    output logic signed [ERR_W-1:0] e,
    output logic                    e_valid
);

    logic [PROD_W-1:0] exact;

    assign exact = PROD_W'(x) * PROD_W'(y);

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= 1'b0;
        end else begin
            e_valid <= valid;
        end
    end

    // NOTE: the error register carries no reset; it is only consumed when e_valid is set.
    always_ff @(posedge clk) begin
        if (valid) begin
            e <= $signed({2'b00, z} - {2'b00, exact});
        end
    end

endmodule

// File: rtl/approx_mult_err_accum.sv
// Error-statistics accumulator for 8x8 approximate multipliers: error sum,
// sum of squared error, max |error| and nonzero-error count over a window.
module approx_mult_err_accum
    import approx_mult_pkg::*;
#(
    parameter int N_SAMPLES = 65536,
    parameter int CNT_W     = 17
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OP_W-1:0]             in_x,
    input  logic [OP_W-1:0]             in_y,
    input  logic [PROD_W-1:0]           in_z,
    output logic                        busy,
    output logic                        done,
    output logic signed [ERR_SUM_W-1:0] err_sum,
    output logic [SSE_W-1:0]            sse,
    output logic [ABS_W-1:0]            max_abs_err,
    output logic [ABS_W-1:0]            nz_count
);

    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        acc_cnt;
    logic                    accept;
    logic                    last_accept;
    logic                    clear;
    logic signed [ERR_W-1:0] s1_e;
    logic                    s1_valid;
    logic                    s2_valid;
    logic [ABS_W-1:0]        abs_e;
    logic [SQ_W-1:0]         sq_e;

    assign in_ready    = (state == RUN) && (acc_cnt < N_CNT);
    assign busy        = (state == RUN) || (state == DRAIN);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (acc_cnt == LAST_CNT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    clear      = 1'b1;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid && !s2_valid) begin
                    done       = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

    approx_err_stage u_err_stage (
        .clk     (clk),
        .rst     (rst),
        .valid   (accept),
        .x       (in_x),
        .y       (in_y),
        .z       (in_z),
        .e       (s1_e),
        .e_valid (s1_valid)
    );

    // Stage 2 has no data register of its own; this bit only tracks the
    // accumulation edge so DRAIN waits for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
    end

    assign abs_e = s1_e[ERR_W-1] ? ABS_W'(-s1_e) : ABS_W'(s1_e);
    assign sq_e  = SQ_W'(abs_e) * SQ_W'(abs_e);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_sum     <= '0;
            sse         <= '0;
            max_abs_err <= '0;
            nz_count    <= '0;
        end else if (s1_valid) begin
            err_sum  <= err_sum + {{(ERR_SUM_W - ERR_W){s1_e[ERR_W-1]}}, s1_e};
            sse      <= sse + SSE_W'(sq_e);
            nz_count <= nz_count + ABS_W'(s1_e != '0);
            if (abs_e > max_abs_err) begin
                max_abs_err <= abs_e;
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_err_accum.sv
// Bench for approx_mult_err_accum: five instances (N_SAMPLES 1, 2, 4 and two
// 65536-sample sweeps) checked against a plain-arithmetic error-statistics model.
module tb_approx_mult_err_accum;

    localparam int N_DUT = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic               start_s    [N_DUT];
    logic               in_valid_s [N_DUT];
    logic               in_ready_s [N_DUT];
    logic [7:0]         x_s        [N_DUT];
    logic [7:0]         y_s        [N_DUT];
    logic [15:0]        z_s        [N_DUT];
    logic               busy_s     [N_DUT];
    logic               done_s     [N_DUT];
    logic signed [33:0] err_sum_s  [N_DUT];
    logic [47:0]        sse_s      [N_DUT];
    logic [16:0]        max_s      [N_DUT];
    logic [16:0]        nz_s       [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int NS = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 65536;
        approx_mult_err_accum #(
            .N_SAMPLES (NS),
            .CNT_W     (17)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start_s[g]),
            .in_valid    (in_valid_s[g]),
            .in_ready    (in_ready_s[g]),
            .in_x        (x_s[g]),
            .in_y        (y_s[g]),
            .in_z        (z_s[g]),
            .busy        (busy_s[g]),
            .done        (done_s[g]),
            .err_sum     (err_sum_s[g]),
            .sse         (sse_s[g]),
            .max_abs_err (max_s[g]),
            .nz_count    (nz_s[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: window statistics from the accepted triples.
    longint m_sum [N_DUT];
    longint m_sse [N_DUT];
    longint m_max [N_DUT];
    longint m_nz  [N_DUT];

    task automatic model_clear(input int i);
        m_sum[i] = 0;
        m_sse[i] = 0;
        m_max[i] = 0;
        m_nz[i]  = 0;
    endtask

    task automatic model_add(input int i, input int x, input int y, input int z);
        longint err;
        longint mag;
        err = longint'(z) - longint'(x) * longint'(y);
        mag = (err < 0) ? -err : err;
        m_sum[i] += err;
        m_sse[i] += err * err;
        if (mag > m_max[i]) m_max[i] = mag;
        if (err != 0) m_nz[i] += 1;
    endtask

    // 4-term nibble-decomposed multiplier with the low x low term truncated.
    function automatic int approx_mul(input int x, input int y);
        int xh, xl, yh, yl;
        xh = x >> 4;
        xl = x & 15;
        yh = y >> 4;
        yl = y & 15;
        return ((xh * yh) << 8) + ((xh * yl) << 4) + ((xl * yh) << 4) + ((xl * yl) & 'hF0);
    endfunction

    task automatic pulse_start(input int i);
        @(negedge clk);
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
        model_clear(i);
    endtask

    task automatic feed(input int i, input logic v, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] z, output logic acc);
        @(negedge clk);
        in_valid_s[i] = v;
        x_s[i] = x;
        y_s[i] = y;
        z_s[i] = z;
        acc = v && in_ready_s[i];
        if (acc) model_add(i, int'(x), int'(y), int'(z));
    endtask

    task automatic send(input int i, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] z);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) feed(i, 1'b1, x, y, z, acc);
        if (!acc) check("send_timeout", 0, 1);
    endtask

    // Called right after the final handshake cycle; done must appear 3 cycles later.
    task automatic wait_done(input int i, input int j);
        int  lat;
        logic seen;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            lat = k;
            if (k == 1) check("in_ready_drop", in_ready_s[i], 0);
            if (done_s[i]) seen = 1'b1;
        end
        check("done_latency", lat, 3);
        if (j != i) check("done_pair", done_s[j], 1);
    endtask

    task automatic after_done(input int i);
        @(negedge clk);
        check("done_single_cycle", done_s[i], 0);
        check("busy_after_done", busy_s[i], 0);
        in_valid_s[i] = 1'b0;
    endtask

    task automatic check_const(input int i, input string pfx, input longint s,
                               input longint q, input longint m, input longint n);
        check({pfx, "_err_sum"}, err_sum_s[i], s);
        check({pfx, "_sse"}, sse_s[i], q);
        check({pfx, "_max_abs_err"}, max_s[i], m);
        check({pfx, "_nz_count"}, nz_s[i], n);
    endtask

    task automatic check_model(input int i, input string pfx);
        check_const(i, pfx, m_sum[i], m_sse[i], m_max[i], m_nz[i]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          hs;
        logic [7:0]  rx, ry;
        logic [15:0] rz;
        logic        saw_done;

        rst = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            start_s[i]    = 1'b0;
            in_valid_s[i] = 1'b0;
            x_s[i]        = '0;
            y_s[i]        = '0;
            z_s[i]        = '0;
            model_clear(i);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < N_DUT; i++) begin
            check("rst_in_ready", in_ready_s[i], 0);
            check("rst_busy", busy_s[i], 0);
            check("rst_done", done_s[i], 0);
            check_const(i, "rst", 0, 0, 0, 0);
        end

        // Single error, N_SAMPLES=1.
        pulse_start(0);
        check("single_busy", busy_s[0], 1);
        send(0, 8'd3, 8'd5, 16'd14);
        wait_done(0, 0);
        check_const(0, "single", -1, 1, 1, 1);
        after_done(0);

        // Extreme errors, N_SAMPLES=2.
        pulse_start(1);
        send(1, 8'd0, 8'd0, 16'd65535);
        send(1, 8'd255, 8'd255, 16'd0);
        wait_done(1, 1);
        check_const(1, "extreme", 510, 64'd8523086850, 65535, 2);
        after_done(1);

        // Random valid gaps, N_SAMPLES=4; in_valid stays high through DRAIN.
        pulse_start(2);
        hs = 0;
        for (int k = 0; k < 200 && hs < 4; k++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rz = ($urandom_range(2) == 0) ? 16'(rx * ry) : 16'($urandom);
            feed(2, 1'($urandom), rx, ry, rz, acc);
            if (acc) hs++;
        end
        check("bp_handshakes", hs, 4);
        wait_done(2, 2);
        check_model(2, "bp");
        after_done(2);

        // Start from DONE clears results and restarts.
        pulse_start(2);
        check("restart_busy", busy_s[2], 1);
        check_const(2, "restart_clear", 0, 0, 0, 0);
        send(2, 8'd10, 8'd10, 16'd0);
        send(2, 8'd200, 8'd3, 16'd7);

        // Start during RUN must not restart the window.
        @(negedge clk);
        in_valid_s[2] = 1'b0;
        start_s[2]    = 1'b1;
        @(negedge clk);
        start_s[2] = 1'b0;
        check("start_in_run_busy", busy_s[2], 1);
        send(2, 8'd17, 8'd9, 16'd153);
        send(2, 8'd255, 8'd1, 16'd300);
        wait_done(2, 2);
        check_model(2, "start_in_run");
        check("start_in_run_sum_const", err_sum_s[2], -648);
        after_done(2);

        // Reset during DRAIN discards the window.
        pulse_start(2);
        for (int k = 0; k < 4; k++) send(2, 8'($urandom), 8'($urandom), 16'($urandom));
        @(negedge clk);
        in_valid_s[2] = 1'b0;
        check("drain_busy", busy_s[2], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("drain_rst_busy", busy_s[2], 0);
        check("drain_rst_in_ready", in_ready_s[2], 0);
        check_const(2, "drain_rst", 0, 0, 0, 0);
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done_s[2]) saw_done = 1'b1;
        end
        check("drain_rst_no_done", saw_done, 0);
        check("drain_rst_idle", busy_s[2], 0);

        // Exhaustive sweeps: instance 3 exact products, instance 4 approximate.
        @(negedge clk);
        start_s[3] = 1'b1;
        start_s[4] = 1'b1;
        @(negedge clk);
        start_s[3] = 1'b0;
        start_s[4] = 1'b0;
        model_clear(3);
        model_clear(4);
        for (int n = 0; n < 65536; n++) begin
            int xv, yv;
            xv  = n >> 8;
            yv  = n & 255;
            acc = 1'b0;
            for (int k = 0; k < 20 && !acc; k++) begin
                @(negedge clk);
                in_valid_s[3] = 1'b1;
                in_valid_s[4] = 1'b1;
                x_s[3] = 8'(xv);
                y_s[3] = 8'(yv);
                z_s[3] = 16'(xv * yv);
                x_s[4] = 8'(xv);
                y_s[4] = 8'(yv);
                z_s[4] = 16'(approx_mul(xv, yv));
                acc = in_ready_s[3] && in_ready_s[4];
            end
            if (!acc) begin
                check("sweep_stall", 0, 1);
                break;
            end
            model_add(3, xv, yv, xv * yv);
            model_add(4, xv, yv, approx_mul(xv, yv));
        end
        wait_done(3, 4);
        check_const(3, "exact_sweep", 0, 0, 0, 0);
        check_model(4, "approx_sweep");
        after_done(3);
        in_valid_s[4] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
